// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch, in-order response FIFO, redirect flush.
// Optional same-cycle response-to-decode bypass when FETCHQ_BYPASS_EN is defined.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [31:0]   hold_pc_q, hold_pc_d, hold_instr_q, hold_instr_d;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];

  logic resp_ok, drop, fifo_vld, credit_ok, req_fire, byp, push, pop;

  always_comb begin
    resp_ok   = imem_resp_valid && (inflight_q != '0);
    drop      = resp_ok && (discard_q != '0);
    fifo_vld  = (count_q != '0);
    credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
    imem_req_valid = rst && !redirect && credit_ok;
    imem_req_addr  = fetch_pc_q;
    req_fire = imem_req_valid && imem_req_ready;
`ifdef FETCHQ_BYPASS_EN
    byp = !fifo_vld && resp_ok && !drop && !redirect;
`else
    byp = 1'b0;
`endif
    out_valid = rst && (fifo_vld || byp);
    if (fifo_vld) begin
      out_pc    = mem_pc[rd_ptr_q];
      out_instr = mem_instr[rd_ptr_q];
    end else if (byp) begin
      out_pc    = resp_pc_q;
      out_instr = imem_resp_data;
    end else begin
      out_pc    = hold_pc_q;
      out_instr = hold_instr_q;
    end
    pop  = fifo_vld && out_ready;
    // A bypassed word that decode takes this cycle never enters the FIFO
    push = resp_ok && !drop && !(byp && out_ready) && !redirect;
  end

  always_comb begin
    count_d      = count_q;
    inflight_d   = inflight_q;
    discard_d    = discard_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    if (out_valid) begin
      hold_pc_d    = out_pc;
      hold_instr_d = out_instr;
    end
    if (redirect) begin
      // Everything still outstanding belongs to the old path
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc & ~32'h3;
      resp_pc_d  = redirect_pc & ~32'h3;
      inflight_d = inflight_q - CW'(resp_ok);
      discard_d  = inflight_q - CW'(resp_ok);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      inflight_d = inflight_q + CW'(req_fire) - CW'(resp_ok);
      if (drop) discard_d = discard_q - CW'(1);
      if (resp_ok && !drop) resp_pc_d = resp_pc_q + 32'd4;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q      <= '0;
      inflight_q   <= '0;
      discard_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= 32'h13;
    end else begin
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_pc[wr_ptr_q]    <= resp_pc_q;
      mem_instr[wr_ptr_q] <= imem_resp_data;
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the IF/ID pipeline register.
- Generates sequential fetch addresses and issues them to a variable-latency instruction memory over a valid/ready request channel.
- Collects in-order responses into a prefetch FIFO and presents {pc, instruction} pairs to decode with a valid/ready handshake.
- A redirect from the branch/jump resolution logic flushes the queue and discards any responses still in flight.

Parameters:
- RESET_PC, 32'h0, fetch address after reset.
- DEPTH, 4, FIFO entries and maximum requests outstanding (power of two, 2..16).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  32  request word address (current fetch_pc).
- imem_req_ready  in  1  memory accepts request.
- imem_resp_valid  in  1  response valid; no backpressure; in order.
- imem_resp_data  in  32  instruction word.
- out_valid  out  1  entry available to decode.
- out_ready  in  1  decode accepts entry.
- out_pc  out  32  pc of head entry.
- out_instr  out  32  instruction of head entry.

Behaviour:
- Reset, sampled on clk while rst==0, sets:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO count=0, inflight=0, discard=0.
  - Outputs: out_valid=0, imem_req_valid=0, out_pc=0, out_instr=32'h13 (nop).
- Reset mid-operation abandons everything. Responses arriving in the cycles after reset are treated as protocol violations and ignored, because inflight=0.
- Request:
  - imem_req_valid = !redirect && (count+inflight) < DEPTH.
  - req_fire = imem_req_valid && imem_req_ready.
  - On fire: fetch_pc += 4, inflight += 1. imem_req_addr = fetch_pc.
- Credit invariant: count+inflight <= DEPTH at all times, so a response can never meet a full FIFO.
- Response handling, when imem_resp_valid=1 and inflight>0:
  - inflight -= 1.
  - If discard>0: drop the word, discard -= 1.
  - Else: push {resp_pc, imem_resp_data}, resp_pc += 4.
  - Response with inflight==0: ignored.
- Output:
  - out_valid = count>0. Head entry is driven on out_pc/out_instr.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - When the FIFO is empty, out_pc/out_instr hold their last values.
- Latency: a response arriving at edge N is visible on out_valid after edge N+1. This is a 1-cycle minimum from response to decode (without the optional feature).
- Redirect has priority over every other event in its cycle. At the next edge:
  - FIFO flushed (count=0). Any pop in that cycle is void; decode flushes too.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - discard = inflight - (imem_resp_valid ? 1 : 0). A response arriving in the redirect cycle is dropped.
  - inflight reduced the same way. No request is issued in the redirect cycle.
- Back-to-back redirects: each one recomputes discard from the current inflight. The last one wins.
- Wrap-around: fetch_pc and resp_pc wrap modulo 2^32, with no error.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined: when count==0, discard==0, no redirect, and a valid response arrives, out_valid=1 combinationally in the same cycle.
  - out_pc=resp_pc, out_instr=imem_resp_data.
  - If out_ready=1, the word is consumed without being written to the FIFO (resp_pc still advances). Otherwise it is pushed as normal.
- Undefined: no combinational path from imem_resp_* to out_*; 1-cycle minimum latency as above.

Test Plan:
- Reset release with RESET_PC=0x100, memory with 2-cycle latency, out_ready=1 -> requests issued to 0x100, 0x104, 0x108, 0x10C. Decode sees pc 0x100, 0x104, 0x108, 0x10C in order with matching instruction words.
- out_ready=0, imem_req_ready=1 -> exactly DEPTH=4 requests issued. imem_req_valid then stays 0. After out_ready=1 pops one entry, exactly one new request is issued.
- 3 requests in flight, redirect to 0x203 with no response that cycle -> next 3 responses dropped. First decode entry has out_pc=0x200. Next request address is 0x200.
- Redirect in the same cycle as a response, with 2 in flight -> that response plus 1 more dropped (discard=1). Out_valid stays 0 until the 0x200 word returns.
- Reset (rst=0) asserted while FIFO holds 2 entries and 1 request is in flight -> next cycle out_valid=0, imem_req_addr=RESET_PC. A stray response is ignored.
- FETCHQ_BYPASS_EN defined, FIFO empty, response 0x00500093 at pc 0x0 with out_ready=1 -> out_valid=1 and out_instr=0x00500093 in the same cycle. FIFO count stays 0.
